// File: rtl/wb_master_engine.sv
// Wishbone classic single-access master: takes one command at a time, runs it on the bus
// with an optional per-access timeout, and returns the result on a valid/ready response port.
module wb_master_engine #(
    parameter int WB_ADDR_WIDTH = 32,
    parameter int WB_DATA_WIDTH = 32,
    parameter int TIMEOUT       = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic                         req_we,
    input  logic [WB_ADDR_WIDTH-1:0]     req_addr,
    input  logic [WB_DATA_WIDTH-1:0]     req_data,
    input  logic [WB_DATA_WIDTH/8-1:0]   req_sel,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [WB_DATA_WIDTH-1:0]     rsp_data,
    output logic [1:0]                   rsp_status,
    output logic                         wb_cyc,
    output logic                         wb_stb,
    output logic                         wb_we,
    output logic [WB_ADDR_WIDTH-1:0]     wb_adr,
    output logic [WB_DATA_WIDTH-1:0]     wb_dat_w,
    output logic [WB_DATA_WIDTH/8-1:0]   wb_sel,
    input  logic [WB_DATA_WIDTH-1:0]     wb_dat_r,
    input  logic                         wb_ack,
    input  logic                         wb_err
);

    localparam int SEL_W   = WB_DATA_WIDTH / 8;
    localparam int CNT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_BUS_ERR = 2'b01;
    localparam logic [1:0] ST_TIMEOUT = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUS,
        S_RESP
    } state_t;

    state_t                     state_q;
    logic                       we_q;
    logic [WB_ADDR_WIDTH-1:0]   adr_q;
    logic [WB_DATA_WIDTH-1:0]   dat_q;
    logic [SEL_W-1:0]           sel_q;
    logic [CNT_W-1:0]           cnt_q;
    logic [WB_DATA_WIDTH-1:0]   rsp_data_q;
    logic [1:0]                 rsp_status_q;
    logic                       in_bus;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            we_q         <= 1'b0;
            adr_q        <= '0;
            dat_q        <= '0;
            sel_q        <= '0;
            cnt_q        <= '0;
            rsp_data_q   <= '0;
            rsp_status_q <= ST_OK;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        adr_q   <= req_addr;
                        dat_q   <= req_data;
                        sel_q   <= req_sel;
                        cnt_q   <= '0;
                        state_q <= S_BUS;
                    end
                end
                S_BUS: begin
                    // Slave responses outrank the timeout, and error outranks ack.
                    if (wb_err) begin
                        rsp_data_q   <= '0;
                        rsp_status_q <= ST_BUS_ERR;
                        state_q      <= S_RESP;
                    end else if (wb_ack) begin
                        rsp_data_q   <= we_q ? '0 : wb_dat_r;
                        rsp_status_q <= ST_OK;
                        state_q      <= S_RESP;
                    end else if (TIMEOUT > 0 && cnt_q == CNT_W'(TO_LAST)) begin
                        rsp_data_q   <= '0;
                        rsp_status_q <= ST_TIMEOUT;
                        state_q      <= S_RESP;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_bus     = (state_q == S_BUS);
    assign req_ready  = (state_q == S_IDLE);
    assign rsp_valid  = (state_q == S_RESP);
    assign rsp_data   = rsp_data_q;
    assign rsp_status = rsp_status_q;
    assign wb_cyc     = in_bus;
    assign wb_stb     = in_bus;
    assign wb_we      = in_bus & we_q;
    assign wb_adr     = in_bus ? adr_q : '0;
    assign wb_dat_w   = in_bus ? dat_q : '0;
    assign wb_sel     = in_bus ? sel_q : '0;

endmodule

// File: tb/tb_wb_master_engine.sv
// Bench for wb_master_engine: directed and randomized commands against a slave model whose
// expected outcome (bus cycles, status, data) is computed from the access rules.
module tb_wb_master_engine;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid, req_ready, req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_data;
    logic [SW-1:0] req_sel;
    logic          rsp_valid, rsp_ready;
    logic [DW-1:0] rsp_data;
    logic [1:0]    rsp_status;
    logic          wb_cyc, wb_stb, wb_we;
    logic [AW-1:0] wb_adr;
    logic [DW-1:0] wb_dat_w;
    logic [SW-1:0] wb_sel;
    logic [DW-1:0] wb_dat_r;
    logic          wb_ack, wb_err;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    wb_master_engine #(
        .WB_ADDR_WIDTH(AW),
        .WB_DATA_WIDTH(DW),
        .TIMEOUT      (TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_sel   (req_sel),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_status(rsp_status),
        .wb_cyc    (wb_cyc),
        .wb_stb    (wb_stb),
        .wb_we     (wb_we),
        .wb_adr    (wb_adr),
        .wb_dat_w  (wb_dat_w),
        .wb_sel    (wb_sel),
        .wb_dat_r  (wb_dat_r),
        .wb_ack    (wb_ack),
        .wb_err    (wb_err)
    );

    // kind: 0 ack, 1 err, 2 ack+err together, 3 slave silent
    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [SW-1:0] sel;
        int            kind;
        int            dly;
        int            stall;
        logic [DW-1:0] rdata;
    } cmd_t;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic cmd_t mk(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                                input logic [SW-1:0] sel, input int kind, input int dly,
                                input int stall, input logic [DW-1:0] rdata);
        cmd_t c;
        c.we = we; c.addr = addr; c.data = data; c.sel = sel;
        c.kind = kind; c.dly = dly; c.stall = stall; c.rdata = rdata;
        return c;
    endfunction

    function automatic cmd_t rnd_cmd();
        int k;
        k = $urandom_range(0, 9);
        return mk(1'($urandom_range(0, 1)), $urandom, $urandom, SW'($urandom_range(0, 15)),
                  (k <= 5) ? 0 : (k <= 7) ? 1 : (k == 8) ? 2 : 3,
                  $urandom_range(0, 5), $urandom_range(0, 3), $urandom);
    endfunction

    task automatic drive_req(input cmd_t c);
        req_valid = 1'b1;
        req_we    = c.we;
        req_addr  = c.addr;
        req_data  = c.data;
        req_sel   = c.sel;
    endtask

    task automatic idle_gap(input int n);
        repeat (n) begin
            wb_ack = 1'($urandom_range(0, 1));
            wb_err = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("idle_ready", 64'(req_ready), 64'(1));
            chk("idle_rspv",  64'(rsp_valid), 64'(0));
            chk("idle_cyc",   64'(wb_cyc),    64'(0));
            chk("idle_adr",   64'(wb_adr),    64'(0));
            chk("idle_we",    64'(wb_we),     64'(0));
        end
        wb_ack = 1'b0;
        wb_err = 1'b0;
    endtask

    // Called at a negedge with the engine idle; returns at the negedge after the response handshake.
    task automatic run_txn(input cmd_t c, input bit hold, input cmd_t nxt);
        int            ncyc;
        bit            timed;
        int            exp_cyc;
        logic [1:0]    exp_st;
        logic [DW-1:0] exp_d;
        timed   = (c.kind == 3) || (c.dly >= TO);
        exp_cyc = timed ? TO : c.dly + 1;
        exp_st  = timed ? 2'b10 : (c.kind == 0) ? 2'b00 : 2'b01;
        exp_d   = (exp_st == 2'b00 && !c.we) ? c.rdata : '0;

        chk("pre_ready", 64'(req_ready), 64'(1));
        chk("pre_cyc",   64'(wb_cyc),    64'(0));
        drive_req(c);
        @(negedge clk);
        if (hold) drive_req(nxt);
        else      req_valid = 1'b0;
        chk("start_cyc", 64'(wb_cyc), 64'(1));
        ncyc = 0;
        while (wb_cyc && ncyc < 40) begin
            chk("bus_stb",   64'(wb_stb),    64'(1));
            chk("bus_we",    64'(wb_we),     64'(c.we));
            chk("bus_adr",   64'(wb_adr),    64'(c.addr));
            chk("bus_dat",   64'(wb_dat_w),  64'(c.data));
            chk("bus_sel",   64'(wb_sel),    64'(c.sel));
            chk("bus_ready", 64'(req_ready), 64'(0));
            chk("bus_rspv",  64'(rsp_valid), 64'(0));
            wb_ack   = 1'b0;
            wb_err   = 1'b0;
            wb_dat_r = $urandom;
            if (c.kind != 3 && ncyc == c.dly) begin
                wb_dat_r = c.rdata;
                wb_ack   = (c.kind != 1);
                wb_err   = (c.kind != 0);
            end
            ncyc++;
            @(negedge clk);
        end
        wb_ack = 1'b0;
        wb_err = 1'b0;
        chk("bus_cycles", 64'(ncyc),       64'(exp_cyc));
        chk("rsp_valid",  64'(rsp_valid),  64'(1));
        chk("rsp_status", 64'(rsp_status), 64'(exp_st));
        chk("rsp_data",   64'(rsp_data),   64'(exp_d));
        rsp_ready = 1'b0;
        repeat (c.stall) begin
            wb_ack = 1'($urandom_range(0, 1));
            wb_err = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("stall_valid",  64'(rsp_valid),  64'(1));
            chk("stall_status", 64'(rsp_status), 64'(exp_st));
            chk("stall_data",   64'(rsp_data),   64'(exp_d));
            chk("stall_ready",  64'(req_ready),  64'(0));
            chk("stall_cyc",    64'(wb_cyc),     64'(0));
        end
        wb_ack    = 1'b0;
        wb_err    = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("done_rspv",  64'(rsp_valid), 64'(0));
        chk("done_ready", 64'(req_ready), 64'(1));
        chk("done_cyc",   64'(wb_cyc),    64'(0));
    endtask

    // Abort an access with rst, either while on the bus or while the response is pending.
    task automatic reset_during(input bit in_resp);
        drive_req(mk(1'b0, 32'h40, 32'h0, 4'hF, 0, 0, 0, 32'hA5A5_0001));
        @(negedge clk);
        req_valid = 1'b0;
        chk("abort_cyc", 64'(wb_cyc), 64'(1));
        if (in_resp) begin
            wb_dat_r = 32'hA5A5_0001;
            wb_ack   = 1'b1;
            @(negedge clk);
            wb_ack = 1'b0;
            chk("abort_in_resp", 64'(rsp_valid), 64'(1));
        end else begin
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_cyc_off",  64'(wb_cyc),     64'(0));
        chk("abort_stb_off",  64'(wb_stb),     64'(0));
        chk("abort_rspv",     64'(rsp_valid),  64'(0));
        chk("abort_ready",    64'(req_ready),  64'(1));
        chk("abort_rsp_data", 64'(rsp_data),   64'(0));
        chk("abort_rsp_st",   64'(rsp_status), 64'(0));
        idle_gap(4);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        cmd_t cur, nxt, dummy;
        bit   hold;
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_data = '0; req_sel = '0;
        rsp_ready = 1'b0; wb_dat_r = '0; wb_ack = 1'b0; wb_err = 1'b0;
        dummy = mk(1'b0, 32'h0, 32'h0, 4'h0, 0, 0, 0, 32'h0);
        repeat (3) @(negedge clk);
        chk("rst_cyc",    64'(wb_cyc),     64'(0));
        chk("rst_stb",    64'(wb_stb),     64'(0));
        chk("rst_rspv",   64'(rsp_valid),  64'(0));
        chk("rst_ready",  64'(req_ready),  64'(1));
        chk("rst_data",   64'(rsp_data),   64'(0));
        chk("rst_status", 64'(rsp_status), 64'(0));
        chk("rst_adr",    64'(wb_adr),     64'(0));
        rst = 1'b0;
        idle_gap(2);

        run_txn(mk(1'b1, 32'h100, 32'hDEAD_BEEF, 4'hF, 0, 1, 0, 32'hFFFF_FFFF), 1'b0, dummy);
        idle_gap(1);
        run_txn(mk(1'b0, 32'h20, 32'h0, 4'hF, 0, 0, 3, 32'h1234_5678), 1'b0, dummy);
        idle_gap(1);
        run_txn(mk(1'b0, 32'h24, 32'h0, 4'hF, 2, 0, 1, 32'h5555_AAAA), 1'b0, dummy);
        idle_gap(1);
        run_txn(mk(1'b0, 32'h28, 32'h0, 4'h3, 3, 0, 0, 32'h0), 1'b0, dummy);
        idle_gap(1);
        run_txn(mk(1'b0, 32'h2C, 32'h0, 4'hF, 0, TO - 1, 0, 32'hCAFE_F00D), 1'b0, dummy);
        run_txn(mk(1'b1, 32'h30, 32'h1, 4'h1, 1, TO - 1, 0, 32'h0), 1'b0, dummy);
        run_txn(mk(1'b0, 32'h34, 32'h0, 4'hF, 0, TO, 0, 32'h7777_7777), 1'b0, dummy);

        cur = mk(1'b1, 32'h200, 32'h0102_0304, 4'hC, 0, 0, 0, 32'h0);
        nxt = mk(1'b0, 32'h204, 32'h0, 4'hF, 0, 2, 0, 32'h0BAD_F00D);
        run_txn(cur, 1'b1, nxt);
        run_txn(nxt, 1'b0, dummy);
        idle_gap(2);

        cur = rnd_cmd();
        for (int i = 0; i < 60; i++) begin
            nxt  = rnd_cmd();
            hold = (i < 59) && ($urandom_range(0, 1) == 1);
            run_txn(cur, hold, nxt);
            if (!hold) idle_gap($urandom_range(0, 2));
            cur = nxt;
        end

        reset_during(1'b0);
        reset_during(1'b1);
        run_txn(mk(1'b0, 32'h300, 32'h0, 4'hF, 0, 1, 1, 32'h600D_D00D), 1'b0, dummy);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
